// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The state enum is also exported on the responder's debug port.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RESP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int          WORD_BYTES       = 4;
  localparam int          CNT_W            = 4;
  localparam logic [31:0] MISALIGNED_RDATA = 32'h0;

  function automatic logic word_aligned(input logic [31:0] byte_addr);
    return byte_addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// The array is not reset; only the read register returns to zero.
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // A write leaves rdata alone so the last load value stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: serialises LDR/STR accesses to a fixed-latency RAM,
// stalls the front of the pipeline while waiting, and parks after a halt.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        is_halt,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic        rsp_is_load,
  output logic [31:0] rsp_rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        halted,
  output state_t      fsm_state
);

  // Handshake: a request is taken on any edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the requester holds its fields until then.
  // rsp_valid is a one-cycle pulse with no back-pressure.

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic             NO_WAIT   = (WAIT_CYCLES == 0);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               halt_pending;
  logic               misaligned_q;
  logic               zero_rdata;

  logic               accept;
  logic               to_resp;
  logic               op_we;
  logic [31:0]        op_addr;
  logic [31:0]        op_wdata;
  logic               op_aligned;
  logic [31:0]        ram_rdata;
  logic               unused_addr_bits;

  assign accept = (state == IDLE) && req_valid;

  // With zero wait cycles the RAM is touched on the accept edge itself,
  // so the operands come straight from the request port in IDLE.
  assign to_resp  = (accept && NO_WAIT) || ((state == WAIT) && (cnt == CNT_W'(1)));
  assign op_we    = (state == IDLE) ? req_we    : we_q;
  assign op_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign op_aligned = word_aligned(op_addr);

  assign unused_addr_bits = ^{op_addr[31:ADDR_W+2], op_addr[1:0]};

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (to_resp && op_aligned),
    .we    (op_we),
    .addr  (op_addr[ADDR_W+1:2]),
    .wdata (op_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      halt_pending <= 1'b0;
      misaligned_q <= 1'b0;
      zero_rdata   <= 1'b0;
    end else begin
      if (is_halt) begin
        halt_pending <= 1'b1;
      end

      if (to_resp && !op_aligned) begin
        misaligned_q <= 1'b1;
      end

      // Only loads change what rsp_rdata shows; stores keep the last load value.
      if (to_resp && !op_we) begin
        zero_rdata <= !op_aligned;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            cnt     <= WAIT_INIT;
            state   <= NO_WAIT ? RESP : WAIT;
          end else if (halt_pending) begin
            state <= HALTED;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state == IDLE);
  assign stall       = (state == WAIT);
  assign rsp_valid   = (state == RESP);
  assign rsp_is_load = (state == RESP) && !we_q;
  assign halted      = (state == HALTED);
  assign misaligned  = misaligned_q;
  assign rsp_rdata   = zero_rdata ? MISALIGNED_RDATA : ram_rdata;
  assign fsm_state   = state;

endmodule
